// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV64 control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing, a data-memory
// ready handshake with timeout, and illegal-opcode trapping.
// Optional macro PERF_CNT_EN enables the retired / stall_cycles performance counters;
// when undefined both outputs are tied to zero.
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7_5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic [3:0]       alu_op_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsR   = 3'd0,
        ClsI   = 3'd1,
        ClsLd  = 3'd2,
        ClsSd  = 3'd3,
        ClsBeq = 3'd4
    } cls_e;

    localparam logic [7:0] TmoLimit = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] tmo_inc;

    assign tmo_inc = tmo_q + 8'd1;

    // State register: FSM state, latched class/ALU op, timeout counter, trap cause.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StFetch;
            cls_q    <= ClsR;
            alu_op_q <= 4'b0000;
            tmo_q    <= 8'd0;
            cause_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            alu_op_q <= alu_op_d;
            tmo_q    <= tmo_d;
            cause_q  <= cause_d;
        end
    end

    // Next-state logic; class and ALU op are captured in DECODE so later outputs ignore opcode.
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        alu_op_d = alu_op_q;
        tmo_d    = tmo_q;
        cause_d  = cause_q;
        case (state_q)
            StFetch: if (run_i) state_d = StDecode;
            StDecode: begin
                state_d = StExec;
                case (opcode_i)
                    7'b0110011: begin
                        cls_d = ClsR;
                        case (funct3_i)
                            3'b000:  alu_op_d = funct7_5_i ? 4'b0110 : 4'b0010;
                            3'b111:  alu_op_d = 4'b0000;
                            3'b110:  alu_op_d = 4'b0001;
                            default: begin
                                state_d = StTrap;
                                cause_d = 2'b01;
                            end
                        endcase
                    end
                    7'b0010011: begin cls_d = ClsI;   alu_op_d = 4'b0010; end
                    7'b0000011: begin cls_d = ClsLd;  alu_op_d = 4'b0010; end
                    7'b0100011: begin cls_d = ClsSd;  alu_op_d = 4'b0010; end
                    7'b1100011: begin cls_d = ClsBeq; alu_op_d = 4'b0110; end
                    default: begin
                        state_d = StTrap;
                        cause_d = 2'b01;
                    end
                endcase
            end
            StExec: begin
                case (cls_q)
                    ClsBeq:       state_d = StFetch;
                    ClsLd, ClsSd: state_d = StMem;
                    default:      state_d = StWb;
                endcase
            end
            StMem: begin
                if (mem_ready_i) begin
                    state_d = (cls_q == ClsSd) ? StFetch : StWb;
                    tmo_d   = 8'd0;
                end else if (tmo_inc == TmoLimit) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Output decode from registered state and latched class.
    always_comb begin
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = 4'b0000;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            alu_op_o  = alu_op_q;
            alu_src_o = (cls_q == ClsI) || (cls_q == ClsLd) || (cls_q == ClsSd);
        end
        case (state_q)
            StFetch: ir_write_o = run_i;
            StExec: begin
                if (cls_q == ClsBeq) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = zero_i;
                end
            end
            StMem: begin
                mem_read_o  = (cls_q == ClsLd);
                mem_write_o = (cls_q == ClsSd);
                pc_write_o  = mem_ready_i && (cls_q == ClsSd);
            end
            StWb: begin
                reg_write_o  = 1'b1;
                pc_write_o   = 1'b1;
                mem_to_reg_o = (cls_q == ClsLd);
            end
            default: ;
        endcase
    end

    assign trap_o       = (state_q == StTrap);
    assign trap_cause_o = cause_q;
    assign state_o      = state_q;

`ifdef PERF_CNT_EN
    logic             retire;
    logic             stall;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    assign retire = ((state_q == StExec) && (cls_q == ClsBeq)) ||
                    ((state_q == StMem) && mem_ready_i && (cls_q == ClsSd)) ||
                    (state_q == StWb);
    assign stall  = (state_q == StMem) && !mem_ready_i;

    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (stall)  stall_q   <= stall_q + CNT_W'(1);
        end
    end

    assign retired_o      = retired_q;
    assign stall_cycles_o = stall_q;
`else
    assign retired_o      = '0;
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares control outputs and counters.
module tb_riscv_multicycle_ctrl;

    localparam int unsigned CNT_W = 32;
`ifdef PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSd  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpBad = 7'b1111111;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

    logic             clk, rst_n, run, funct7_5, zero, mem_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             ir_write, pc_write, pc_src, reg_write, alu_src;
    logic [3:0]       alu_op;
    logic             mem_read, mem_write, mem_to_reg, trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired, stall_cycles;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .run_i         (run),
        .opcode_i      (opcode),
        .funct3_i      (funct3),
        .funct7_5_i    (funct7_5),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .ir_write_o    (ir_write),
        .pc_write_o    (pc_write),
        .pc_src_o      (pc_src),
        .reg_write_o   (reg_write),
        .alu_src_o     (alu_src),
        .alu_op_o      (alu_op),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .mem_to_reg_o  (mem_to_reg),
        .trap_o        (trap),
        .trap_cause_o  (trap_cause),
        .state_o       (state),
        .retired_o     (retired),
        .stall_cycles_o(stall_cycles)
    );

    typedef struct packed {
        logic [17:0]      ctl;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] stl;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    int               entry = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic [CNT_W-1:0] exp_stall = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] ctl(input logic [2:0] st, input logic ir, input logic pcw,
                                        input logic pcs, input logic rw, input logic as,
                                        input logic [3:0] aop, input logic mr, input logic mw,
                                        input logic m2r, input logic tr, input logic [1:0] cs);
        return {st, ir, pcw, pcs, rw, as, aop, mr, mw, m2r, tr, cs};
    endfunction

    task automatic push(input logic [17:0] c);
        exp_t e;
        e.ctl = c;
        e.ret = PerfEn ? exp_ret : '0;
        e.stl = PerfEn ? exp_stall : '0;
        sb.push_back(e);
    endtask

    // Drive inputs for one cycle, queue the expected outputs, advance to just past the edge.
    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic rdy, input logic [17:0] c);
        run = r; opcode = op; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = rdy;
        push(c);
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle; outputs must clear before the next clock edge.
    task automatic pulse_reset();
        run = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_ret = '0;
        exp_stall = '0;
        push(18'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs at every falling edge that has a queued expectation.
    initial begin
        exp_t        e;
        logic [17:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                got = {state, ir_write, pc_write, pc_src, reg_write, alu_src, alu_op,
                       mem_read, mem_write, mem_to_reg, trap, trap_cause};
                tests++;
                if (got !== e.ctl) begin
                    fails++;
                    $display("FAIL ctl[%0d] got %b required %b", entry, got, e.ctl);
                end
                tests++;
                if (retired !== e.ret) begin
                    fails++;
                    $display("FAIL retired[%0d] got %0d required %0d", entry, retired, e.ret);
                end
                tests++;
                if (stall_cycles !== e.stl) begin
                    fails++;
                    $display("FAIL stall[%0d] got %0d required %0d", entry, stall_cycles, e.stl);
                end
                entry++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        #1;
        push(18'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle with run=0
        step(0, OpR, 3'b000, 1, 0, 0, 18'd0);

        // R-type SUB: 0,1,2,4
        step(1, OpR, 3'b000, 1, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b000, 1, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b000, 1, 0, 0, ctl(E, 0, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b000, 1, 0, 0, ctl(W, 0, 1, 0, 1, 0, 4'b0110, 0, 0, 0, 0, 2'b00));
        exp_ret = 1;

        // LD with three stall cycles
        step(1, OpLd, 3'b011, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpLd, 3'b011, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpLd, 3'b011, 0, 0, 0, ctl(E, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 2'b00));
        for (int i = 0; i < 3; i++) begin
            step(1, OpLd, 3'b011, 0, 0, 0, ctl(M, 0, 0, 0, 0, 1, 4'b0010, 1, 0, 0, 0, 2'b00));
            exp_stall = exp_stall + 1;
        end
        step(1, OpLd, 3'b011, 0, 0, 1, ctl(M, 0, 0, 0, 0, 1, 4'b0010, 1, 0, 0, 0, 2'b00));
        step(1, OpLd, 3'b011, 0, 0, 0, ctl(W, 0, 1, 0, 1, 1, 4'b0010, 0, 0, 1, 0, 2'b00));
        exp_ret = 2;

        // BEQ taken, then not taken
        step(1, OpBeq, 3'b000, 0, 1, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpBeq, 3'b000, 0, 1, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpBeq, 3'b000, 0, 1, 0, ctl(E, 0, 1, 1, 0, 0, 4'b0110, 0, 0, 0, 0, 2'b00));
        exp_ret = 3;
        step(1, OpBeq, 3'b000, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpBeq, 3'b000, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpBeq, 3'b000, 0, 0, 0, ctl(E, 0, 1, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 2'b00));
        exp_ret = 4;

        // R-type AND
        step(1, OpR, 3'b111, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b111, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b111, 0, 0, 0, ctl(E, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b111, 0, 0, 0, ctl(W, 0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        exp_ret = 5;

        // ADDI
        step(1, OpI, 3'b000, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpI, 3'b000, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpI, 3'b000, 0, 0, 0, ctl(E, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 2'b00));
        step(1, OpI, 3'b000, 0, 0, 0, ctl(W, 0, 1, 0, 1, 1, 4'b0010, 0, 0, 0, 0, 2'b00));
        exp_ret = 6;

        // SD with memory ready on the first MEM cycle
        step(1, OpSd, 3'b011, 0, 0, 1, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 1, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 1, ctl(E, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 1, ctl(M, 0, 1, 0, 0, 1, 4'b0010, 0, 1, 0, 0, 2'b00));
        exp_ret = 7;

        // SD timeout: 15 MEM cycles of MemWrite, then TRAP cause 10
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(E, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 2'b00));
        for (int i = 0; i < 15; i++) begin
            step(1, OpSd, 3'b011, 0, 0, 0, ctl(M, 0, 0, 0, 0, 1, 4'b0010, 0, 1, 0, 0, 2'b00));
            exp_stall = exp_stall + 1;
        end
        for (int i = 0; i < 2; i++) begin
            step(1, OpSd, 3'b011, 0, 0, 1, ctl(T, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b10));
        end
        pulse_reset();

        // Illegal opcode, held in TRAP until reset mid-TRAP
        step(1, OpBad, 3'b000, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpBad, 3'b000, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        for (int i = 0; i < 3; i++) begin
            step(1, OpR, 3'b000, 0, 0, 1, ctl(T, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b01));
        end
        pulse_reset();
        step(0, OpR, 3'b000, 0, 0, 0, 18'd0);

        // R-type with unsupported funct3
        step(1, OpR, 3'b001, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpR, 3'b001, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        for (int i = 0; i < 2; i++) begin
            step(1, OpR, 3'b001, 0, 0, 0, ctl(T, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b01));
        end
        pulse_reset();

        // Asynchronous reset in the middle of an SD MEM stall
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(F, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(D, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(E, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 2'b00));
        step(1, OpSd, 3'b011, 0, 0, 0, ctl(M, 0, 0, 0, 0, 1, 4'b0010, 0, 1, 0, 0, 2'b00));
        exp_stall = exp_stall + 1;
        pulse_reset();
        step(0, OpSd, 3'b011, 0, 0, 1, 18'd0);

        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV64 datapath (PC, register file, ALU, data memory, write-back mux) one instruction at a time.
- Drives RegWrite, ALUSrc, ALUop, MemWrite, MemRead, MemtoReg, plus PC/IR enables and the branch select.
- Handles a ready handshake to data memory, with timeout, and traps on illegal opcodes.
- Replaces the single-cycle controller so that memory may take more than one cycle.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for mem_ready before trapping; legal range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  enables leaving FETCH.
- opcode  input  7  instruction[6:0], taken from the datapath instruction bus.
- funct3  input  3  instruction[14:12].
- funct7_5  input  1  instruction[30].
- zero  input  1  zero flag from the main ALU.
- mem_ready  input  1  data memory has completed the access in progress.
- IRWrite  output  1  latch the instruction.
- PCWrite  output  1  update the PC.
- PCSrc  output  1  selects the next PC: 0 = pc+4, 1 = branch target.
- RegWrite  output  1  register file write enable.
- ALUSrc  output  1  ALU operand B select: 0 = register, 1 = immediate.
- ALUop  output  4  ALU operation code.
- MemRead  output  1  data memory read enable.
- MemWrite  output  1  data memory write enable.
- MemtoReg  output  1  write-back select: 1 = memory data, 0 = ALU result.
- trap  output  1  sticky error flag.
- trap_cause  output  2  error code: 00 none, 01 illegal opcode, 10 memory timeout.
- state  output  3  current FSM state, for debug.
- retired  output  CNT_W  count of completed instructions.
- stall_cycles  output  CNT_W  count of MEM cycles with mem_ready=0.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (reset=0, asynchronous):
  - state=FETCH, class register=0, timeout counter=0, trap=0, trap_cause=00, counters=0.
  - With run=0, every output is 0.
- Outputs are decoded from the registered state and the latched class. There are no output glitches from opcode once the class is latched.
- FETCH: IRWrite=run. Go to DECODE if run=1, otherwise stay in FETCH.
- DECODE: latch the class from opcode.
  - 0110011 → R
  - 0010011 → I (ADDI only)
  - 0000011 → LD
  - 0100011 → SD
  - 1100011 → BEQ
  - Any other opcode → TRAP, trap_cause=01.
  - Otherwise go to EXEC.
- ALUop (valid in EXEC, MEM and WB):
  - LD, SD, I: 0010 (add).
  - BEQ: 0110 (sub).
  - R with funct3=000: 0110 if funct7_5=1, else 0010.
  - R with funct3=111: 0000 (and).
  - R with funct3=110: 0001 (or).
  - Any other R funct3 → TRAP, trap_cause=01, taken at the DECODE→EXEC transition.
- ALUSrc=1 for I, LD and SD; 0 otherwise.
- EXEC:
  - BEQ: PCWrite=1, PCSrc=zero (sampled this cycle), retired++, then FETCH. Total 3 cycles.
  - LD, SD: go to MEM.
  - R, I: go to WB.
- MEM:
  - LD asserts MemRead=1; SD asserts MemWrite=1. Held continuously until mem_ready=1.
  - mem_ready is sampled only in MEM. mem_ready=1 on the first MEM cycle gives a 1-cycle MEM.
  - SD completion: PCWrite=1, PCSrc=0, retired++, then FETCH.
  - LD completion: go to WB.
  - Each cycle in MEM with mem_ready=0 increments the timeout counter and stall_cycles.
  - If the counter reaches MEM_TIMEOUT while mem_ready=0 → TRAP, trap_cause=10, with MemRead/MemWrite deasserted in TRAP.
  - The counter clears on leaving MEM.
- WB:
  - RegWrite=1, PCWrite=1, PCSrc=0, retired++, then FETCH.
  - MemtoReg=1 for LD, 0 for R and I.
- Latency with ready memory: R/I = 4 cycles, LD = 5, SD = 4, BEQ = 3.
- TRAP: absorbing state. All enables are 0, trap=1, and trap_cause is held. Only reset exits.
- run affects FETCH only. Deasserting run mid-instruction does not stop that instruction.
- Reset asserted mid-operation clears all state immediately. No partial write completes after reset.
- Counters wrap modulo 2^CNT_W.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined: retired and stall_cycles count as described above.
- Undefined: both ports are tied to 0 and no counter flops are inferred. FSM behaviour is identical.

Test Plan:
- R-type: reset, run=1, opcode=0110011, funct3=000, funct7_5=1 → state sequence 0,1,2,4; ALUop=0110 in EXEC and WB; RegWrite=1 only in WB; retired=1.
- LD: opcode=0000011, mem_ready held 0 for 3 MEM cycles then 1 → MemRead=1 for 4 cycles; then WB with MemtoReg=1, RegWrite=1; stall_cycles=3.
- BEQ: opcode=1100011, zero=1 in EXEC → PCWrite=1, PCSrc=1, no RegWrite; back in FETCH at cycle 3. Repeat with zero=0 → PCSrc=0.
- Memory timeout: SD with mem_ready stuck at 0 and MEM_TIMEOUT=15 → MemWrite=1 for 15 cycles, then state=5, trap=1, trap_cause=10, MemWrite=0.
- Illegal opcode 1111111 → TRAP after DECODE, trap_cause=01; held until reset is pulsed low mid-TRAP, then state=0 and all outputs 0.
- Asynchronous reset asserted mid-MEM of an SD → MemWrite drops in the same cycle without a clock edge; retired is unchanged (0).
